// File: rtl/gfx_store_coalescer.sv
// rtl/gfx_store_coalescer.sv - write-combining stage merging 32-bit pixel stores into 128-bit masked line writes
module gfx_store_coalescer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         gfx_st_valid,
  input  logic [31:0]  gfx_st_addr,
  input  logic [31:0]  gfx_st_wdata,
  input  logic [3:0]   gfx_st_wstrb,
  output logic         gfx_st_ready,
  input  logic         flush_req,
  output logic         mem_wr_valid,
  output logic [31:0]  mem_wr_addr,
  output logic [127:0] mem_wr_data,
  output logic [15:0]  mem_wr_strb,
  input  logic         mem_wr_ready,
  output logic         idle
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_OPEN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic [27:0]      line_addr;
  logic [127:0]     line_data;
  logic [15:0]      line_strb;
  logic [CNT_W-1:0] idle_cnt;

  logic         same_line;
  logic         accept;
  logic         timeout_hit;
  logic [15:0]  base_strb;
  logic [127:0] merged_data;
  logic [15:0]  merged_strb;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^gfx_st_addr[1:0];

  always_comb begin
    same_line = (gfx_st_addr[31:4] == line_addr);
    case (state)
      ST_EMPTY: gfx_st_ready = 1'b1;
      ST_OPEN:  gfx_st_ready = same_line;
      default:  gfx_st_ready = 1'b0;
    endcase
    accept      = gfx_st_valid && gfx_st_ready;
    timeout_hit = TO_EN && (idle_cnt == TO_LAST);
    // A fresh line starts with no valid bytes; stale data is masked by the strobe.
    base_strb   = (state == ST_EMPTY) ? 16'h0000 : line_strb;
    merged_data = line_data;
    merged_strb = base_strb;
    for (int l = 0; l < 4; l++) begin
      for (int j = 0; j < 4; j++) begin
        if ((gfx_st_addr[3:2] == 2'(l)) && gfx_st_wstrb[j]) begin
          merged_data[32*l+8*j +: 8] = gfx_st_wdata[8*j +: 8];
          merged_strb[4*l+j]         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      line_addr <= '0;
      line_data <= '0;
      line_strb <= '0;
      idle_cnt  <= '0;
    end else if (accept) begin
      line_data <= merged_data;
      line_strb <= merged_strb;
      idle_cnt  <= '0;
      if (state == ST_EMPTY) begin
        line_addr <= gfx_st_addr[31:4];
      end
      // A flush coinciding with a same-line store drains the line including that store.
      if ((merged_strb == 16'hFFFF) || ((state == ST_OPEN) && flush_req)) begin
        state <= ST_DRAIN;
      end else begin
        state <= ST_OPEN;
      end
    end else begin
      case (state)
        ST_OPEN: begin
          if (gfx_st_valid || flush_req || timeout_hit) begin
            state <= ST_DRAIN;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (mem_wr_ready) begin
            line_strb <= '0;
            idle_cnt  <= '0;
            state     <= ST_EMPTY;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_wr_valid = (state == ST_DRAIN);
  assign mem_wr_addr  = {line_addr, 4'b0000};
  assign mem_wr_data  = line_data;
  assign mem_wr_strb  = line_strb;
  assign idle         = (state == ST_EMPTY);

endmodule

// File: tb/tb_gfx_store_coalescer.sv
// tb/tb_gfx_store_coalescer.sv - scoreboard bench for gfx_store_coalescer
module tb_gfx_store_coalescer;

  logic         clk;
  logic         rst_n;
  logic         gfx_st_valid;
  logic [31:0]  gfx_st_addr;
  logic [31:0]  gfx_st_wdata;
  logic [3:0]   gfx_st_wstrb;
  logic         gfx_st_ready;
  logic         flush_req;
  logic         mem_wr_valid;
  logic [31:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic [15:0]  mem_wr_strb;
  logic         mem_wr_ready;
  logic         idle;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  gfx_store_coalescer #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gfx_st_valid (gfx_st_valid),
    .gfx_st_addr  (gfx_st_addr),
    .gfx_st_wdata (gfx_st_wdata),
    .gfx_st_wstrb (gfx_st_wstrb),
    .gfx_st_ready (gfx_st_ready),
    .flush_req    (flush_req),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_strb  (mem_wr_strb),
    .mem_wr_ready (mem_wr_ready),
    .idle         (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] strb_mask(input logic [15:0] s);
    logic [127:0] m;
    for (int b = 0; b < 16; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed write handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mem_wr_valid && mem_wr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h strb %h, expected no write", mem_wr_addr, mem_wr_strb);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 128'(mem_wr_addr), 128'(e.addr));
        chk("wr_strb", 128'(mem_wr_strb), 128'(e.strb));
        chk("wr_data", mem_wr_data & strb_mask(e.strb), e.data & strb_mask(e.strb));
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int waits);
    gfx_st_valid = 1'b1;
    gfx_st_addr  = a;
    gfx_st_wdata = d;
    gfx_st_wstrb = s;
    waits = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gfx_st_ready) break;
      waits++;
    end
    if (!gfx_st_ready) begin
      checks++;
      errors++;
      $display("FAIL store_accept: got ready 0 for 100 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    gfx_st_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (idle) break;
      n++;
    end
    chk(name, 128'(idle), 128'(1));
  endtask

  initial begin
    int w;
    rst_n        = 1'b0;
    gfx_st_valid = 1'b0;
    gfx_st_addr  = '0;
    gfx_st_wdata = '0;
    gfx_st_wstrb = '0;
    flush_req    = 1'b0;
    mem_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_st_ready", 128'(gfx_st_ready), 128'(1));
    chk("rst_wr_valid", 128'(mem_wr_valid), 128'(0));
    chk("rst_wr_addr",  128'(mem_wr_addr),  128'(0));
    chk("rst_wr_data",  mem_wr_data,        128'(0));
    chk("rst_wr_strb",  128'(mem_wr_strb),  128'(0));
    chk("rst_idle",     128'(idle),         128'(1));

    // flush in EMPTY does nothing
    flush_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("empty_flush_idle", 128'(idle), 128'(1));
    chk("empty_flush_valid", 128'(mem_wr_valid), 128'(0));
    @(posedge clk); #1;
    flush_req = 1'b0;

    // Full line
    exp_q.push_back('{32'h2000, {4{32'h55AA1234}}, 16'hFFFF});
    @(posedge clk); #1;
    do_store(32'h2000, 32'h55AA1234, 4'hF, w);
    do_store(32'h2004, 32'h55AA1234, 4'hF, w);
    do_store(32'h2008, 32'h55AA1234, 4'hF, w);
    do_store(32'h200C, 32'h55AA1234, 4'hF, w);
    @(negedge clk);
    chk("full_line_latency", 128'(mem_wr_valid), 128'(1));
    wait_idle("full_line_done");
    chk("full_line_count", 128'(exp_q.size()), 128'(0));

    // Line change
    exp_q.push_back('{32'h2000, {96'h0, 32'hDEADBEEF}, 16'h000F});
    exp_q.push_back('{32'h2020, {96'h0, 32'h01020304}, 16'h000F});
    do_store(32'h2000, 32'hDEADBEEF, 4'hF, w);
    do_store(32'h2020, 32'h01020304, 4'hF, w);
    chk("line_change_stall", 128'(w), 128'(2));
    wait_idle("line_change_done");
    chk("line_change_count", 128'(exp_q.size()), 128'(0));

    // Timeout
    exp_q.push_back('{32'h2000, {32'h0, 32'h0000CCDD, 64'h0}, 16'h0300});
    do_store(32'h2008, 32'hAABBCCDD, 4'h3, w);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("timeout_early", 128'(mem_wr_valid), 128'(0));
    @(negedge clk);
    chk("timeout_fire", 128'(mem_wr_valid), 128'(1));
    wait_idle("timeout_done");
    chk("timeout_count", 128'(exp_q.size()), 128'(0));

    // Merge overwrite then flush
    exp_q.push_back('{32'h2000, {64'h0, 32'h1111FF11, 32'h0}, 16'h00F0});
    do_store(32'h2004, 32'h11111111, 4'hF, w);
    do_store(32'h2004, 32'h0000FF00, 4'h2, w);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    @(negedge clk);
    chk("flush_latency", 128'(mem_wr_valid), 128'(1));
    wait_idle("merge_done");
    chk("merge_count", 128'(exp_q.size()), 128'(0));

    // Zero-strobe store still opens a line
    exp_q.push_back('{32'h5000, 128'h0, 16'h0000});
    do_store(32'h5004, 32'hFFFFFFFF, 4'h0, w);
    chk("zero_strb_open", 128'(idle), 128'(0));
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    wait_idle("zero_strb_done");
    chk("zero_strb_count", 128'(exp_q.size()), 128'(0));

    // Backpressure
    mem_wr_ready = 1'b0;
    exp_q.push_back('{32'h3000, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 16'hFFFF});
    do_store(32'h3000, 32'hA0A0A0A0, 4'hF, w);
    do_store(32'h3004, 32'hB1B1B1B1, 4'hF, w);
    do_store(32'h3008, 32'hC2C2C2C2, 4'hF, w);
    do_store(32'h300C, 32'hD3D3D3D3, 4'hF, w);
    gfx_st_valid = 1'b1;
    gfx_st_addr  = 32'h3000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid",    128'(mem_wr_valid), 128'(1));
      chk("bp_st_ready", 128'(gfx_st_ready), 128'(0));
      chk("bp_addr",     128'(mem_wr_addr),  128'(32'h3000));
      chk("bp_strb",     128'(mem_wr_strb),  128'(16'hFFFF));
      chk("bp_data",     mem_wr_data, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0});
    end
    @(posedge clk); #1;
    gfx_st_valid = 1'b0;
    mem_wr_ready = 1'b1;
    wait_idle("bp_done");
    repeat (5) @(negedge clk);
    chk("bp_count", 128'(exp_q.size()), 128'(0));

    // Reset mid-drain
    mem_wr_ready = 1'b0;
    do_store(32'h4000, 32'h12345678, 4'hF, w);
    do_store(32'h4004, 32'h12345678, 4'hF, w);
    do_store(32'h4008, 32'h12345678, 4'hF, w);
    do_store(32'h400C, 32'h12345678, 4'hF, w);
    @(negedge clk);
    chk("pre_rst_valid", 128'(mem_wr_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_drain_valid", 128'(mem_wr_valid), 128'(0));
    chk("rst_drain_idle",  128'(idle),         128'(1));
    mem_wr_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_idle",  128'(idle),         128'(1));
    chk("post_rst_valid", 128'(mem_wr_valid), 128'(0));
    chk("final_queue",    128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
